// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, pin masks and ui_in bit positions for seg7_tick_counter
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  localparam logic [7:0] UIO_OE_MASK = 8'h3F;
  localparam int UI_RUN = 0;
  localparam int UI_DIR = 1;
  localparam int UI_HEX = 2;
  localparam int UI_LOAD = 3;
  localparam int UI_VAL = 4;
endpackage

// File: rtl/seg7_tick_counter_if.sv
// seg7_tick_counter_if: Tiny Tapeout style pin bundle between host/bench and the counter
interface seg7_tick_counter_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational 4-bit value to 7-segment glyph (bit0 = a, active high)
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[val];
endmodule

// File: rtl/seg7_tick_counter.sv
// seg7_tick_counter: prescaled up/down dec/hex counter driving one 7-segment digit
// Define SEG7_ACTIVE_LOW_EN for an inverted (common-anode) uo_out.
module seg7_tick_counter
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 24,
  parameter logic [PRESCALE_W-1:0] MAX_COUNT = 24'd10_000_000
) (
  input logic clk,
  input logic rst_n,
  input logic ena,
  seg7_tick_counter_if.slave bus
);
`ifdef SEG7_ACTIVE_LOW_EN
  localparam logic [7:0] UO_POL = 8'hFF;
`else
  localparam logic [7:0] UO_POL = 8'h00;
`endif
  localparam logic [PRESCALE_W-1:0] PRE_LAST = MAX_COUNT - 1'b1;
  logic [7:0] s1_q, s1_d, s2_q, s2_d, uo_q, uo_d;
  logic s3_q, s3_d, dp_q, dp_d, tick_q, tick_d, wrap_q, wrap_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [3:0] cnt_q, cnt_d, ld_val, step_val, val;
  logic [6:0] seg;
  logic run, dir, hex, load, tick, step_wrap, unused_uio;
  seg7_decoder u_dec (.val(cnt_q), .seg(seg));
  always_comb begin
    run = s2_q[UI_RUN];
    dir = s2_q[UI_DIR];
    hex = s2_q[UI_HEX];
    val = s2_q[UI_VAL +: 4];
    load = ena & s2_q[UI_LOAD] & ~s3_q;
    tick = ena & run & (pre_q == PRE_LAST);
    // an out-of-range value left over from hex mode wraps like a terminal count
    step_wrap = (~hex & (cnt_q > 4'd9)) | (dir ? cnt_q == 4'd0 : cnt_q == (hex ? 4'hF : 4'd9));
    step_val = step_wrap ? (dir ? (hex ? 4'hF : 4'd9) : 4'd0) : (dir ? cnt_q - 4'd1 : cnt_q + 4'd1);
    ld_val = (~hex & (val > 4'd9)) ? 4'd9 : val;
    s1_d = bus.ui_in;
    s2_d = s1_q;
    s3_d = s2_q[UI_LOAD];
    pre_d = load ? '0 : (ena & run) ? (tick ? '0 : pre_q + 1'b1) : pre_q;
    cnt_d = load ? ld_val : tick ? step_val : cnt_q;
    wrap_d = tick & ~load & step_wrap;
    dp_d = dp_q ^ wrap_d;
    tick_d = tick;
    uo_d = ena ? UO_POL ^ {dp_q, seg} : uo_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= 1'b0;
      pre_q <= '0;
      cnt_q <= '0;
      dp_q <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      uo_q <= UO_POL ^ {1'b0, SEG_0};
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      dp_q <= dp_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      uo_q <= uo_d;
    end
  end
  assign unused_uio = ^bus.uio_in;
  assign bus.uo_out = uo_q;
  assign bus.uio_out = {2'b00, wrap_q, tick_q, cnt_q};
  assign bus.uio_oe = UIO_OE_MASK;
endmodule

// File: tb/tb_seg7_tick_counter.sv
// tb_seg7_tick_counter: directed checks of the tick counter with MAX_COUNT=4 plus a MAX_COUNT=1 instance
module tb_seg7_tick_counter;
`ifdef SEG7_ACTIVE_LOW_EN
  localparam logic [7:0] POL = 8'hFF;
`else
  localparam logic [7:0] POL = 8'h00;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic exp_dp = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t, tp, ts;
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  seg7_tick_counter_if bus();
  seg7_tick_counter_if bus1();
  seg7_tick_counter #(.PRESCALE_W(24), .MAX_COUNT(24'd4)) dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus.slave));
  seg7_tick_counter #(.PRESCALE_W(24), .MAX_COUNT(24'd1)) dut1 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1.slave));
  assign bus.uio_in = '0;
  assign bus1.uio_in = '0;
  assign bus1.ui_in = bus.ui_in;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic wait_tick(output int tt);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.uio_out[4] && n < 40);
    chk("tick_seen", {31'd0, bus.uio_out[4]}, 1);
    tt = cyc;
  endtask
  task automatic check_tick(input string tag, input logic [3:0] c, input logic w, output int tt);
    wait_tick(tt);
    chk({tag, "_cnt"}, {28'd0, bus.uio_out[3:0]}, {28'd0, c});
    chk({tag, "_wrap"}, {31'd0, bus.uio_out[5]}, {31'd0, w});
    if (w) exp_dp = ~exp_dp;
    @(negedge clk);
    chk({tag, "_seg"}, {24'd0, bus.uo_out}, {24'd0, POL ^ {exp_dp, glyph[c]}});
    chk({tag, "_pulse"}, {30'd0, bus.uio_out[5:4]}, 0);
  endtask
  initial begin
    bus.ui_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_uo", {24'd0, bus.uo_out}, {24'd0, POL ^ 8'h3F});
    chk("rst_uio", {24'd0, bus.uio_out}, 0);
    chk("uio_oe", {24'd0, bus.uio_oe}, 32'h3F);
    bus.ui_in = 8'h01;
    rst_n = 1'b1;
    ts = cyc;
    repeat (3) @(negedge clk);
    chk("max1_a", {27'd0, bus1.uio_out[4:0]}, 32'h11);
    @(negedge clk);
    chk("max1_b", {27'd0, bus1.uio_out[4:0]}, 32'h12);
    check_tick("up1", 4'd1, 1'b0, t);
    chk("first_lat", t - ts, 6);
    for (int i = 2; i <= 10; i++) begin
      tp = t;
      check_tick("up", 4'(i % 10), i == 10, t);
      chk("period", t - tp, 4);
    end
    bus.ui_in = 8'h07;
    check_tick("dn_hex_wrap", 4'hF, 1'b1, t);
    check_tick("dn_hex_e", 4'hE, 1'b0, t);
    check_tick("dn_hex_d", 4'hD, 1'b0, t);
    check_tick("dn_hex_c", 4'hC, 1'b0, t);
    check_tick("dn_hex_b", 4'hB, 1'b0, t);
    bus.ui_in = 8'h01;
    check_tick("dec_up_over", 4'd0, 1'b1, t);
    bus.ui_in = 8'hBC;
    repeat (2) @(negedge clk);
    chk("load_early", {24'd0, bus.uio_out}, 0);
    @(negedge clk);
    chk("load_hex_b", {24'd0, bus.uio_out}, 32'h0B);
    @(negedge clk);
    chk("load_seg", {24'd0, bus.uo_out}, {24'd0, POL ^ {exp_dp, glyph[11]}});
    bus.ui_in = 8'h03;
    ts = cyc;
    check_tick("dec_dn_over", 4'd9, 1'b1, t);
    chk("load_pre_lat", t - ts, 6);
    check_tick("dn8", 4'd8, 1'b0, t);
    bus.ui_in = 8'hC8;
    repeat (3) @(negedge clk);
    chk("load_clamp", {24'd0, bus.uio_out}, 32'h09);
    @(negedge clk);
    chk("clamp_seg", {24'd0, bus.uo_out}, {24'd0, POL ^ {exp_dp, glyph[9]}});
    bus.ui_in = 8'h01;
    ts = cyc;
    check_tick("clamp_up", 4'd0, 1'b1, t);
    chk("clamp_pre_lat", t - ts, 6);
    bus.ui_in = 8'h59;
    tp = t;
    check_tick("coinc", 4'd5, 1'b0, t);
    chk("coinc_period", t - tp, 4);
    tp = t;
    check_tick("post_load", 4'd6, 1'b0, t);
    chk("post_period", t - tp, 4);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) bus.ui_in = 8'h01;
      if (i == 9) bus.ui_in = 8'h39;
      chk("frz_uio", {24'd0, bus.uio_out}, 32'h06);
      chk("frz_uo", {24'd0, bus.uo_out}, {24'd0, POL ^ {exp_dp, glyph[6]}});
    end
    ena = 1'b1;
    ts = cyc;
    check_tick("resume", 4'd7, 1'b0, t);
    chk("resume_lat", t - ts, 3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_uio", {24'd0, bus.uio_out}, 0);
    chk("rst2_uo", {24'd0, bus.uo_out}, {24'd0, POL ^ 8'h3F});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_load_early", {28'd0, bus.uio_out[3:0]}, 0);
    @(negedge clk);
    chk("rst_load", {24'd0, bus.uio_out}, 32'h03);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
